lib_allocator_islip_iter: RTL and testbench

Parametrised N-input, M-output iterative iSLIP separable allocator with request-grant-accept matching over up to ITER iterations per allocation. Per-output grant pointers and per-input accept pointers update only on first-iteration matches. An allocation is started by a pulse and can terminate early. The block sits between the VOQ request logic of a switch input stage and the crossbar configuration register. Each allocation produces a conflict-free match matrix and a one-cycle valid strobe.

---
 rtl/lib_allocator_islip_iter.sv | 174 +++++++++++++++++
 tb/tb_lib_allocator_islip_iter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lib_allocator_islip_iter.sv
// Iterative iSLIP separable allocator: N inputs, M outputs, up to ITER
// request-grant-accept iterations per allocation, one iteration per cycle.
module lib_allocator_islip_iter #(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int ITER = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                i_start,
    input  logic [N-1:0][M-1:0] i_request,
    output logic                o_ready,
    output logic                o_valid,
    output logic [M-1:0][N-1:0] o_grant
);

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = $clog2(ITER + 1);

    typedef enum logic [1:0] {
        IDLE,
        ITERATE,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [N-1:0][M-1:0] req_q, req_d;
    logic [M-1:0][N-1:0] match_q, match_d;
    logic [M-1:0][N-1:0] grant_q, grant_d;
    logic [M-1:0][NW-1:0] gptr_q, gptr_d;
    logic [N-1:0][MW-1:0] aptr_q, aptr_d;
    logic [KW-1:0]       iter_q, iter_d;

    logic [M-1:0]        out_busy;
    logic [N-1:0]        in_busy;
    logic [M-1:0][N-1:0] gnt_w;
    logic [M-1:0][N-1:0] acc_w;
    logic [M-1:0]        g_found;
    logic [N-1:0]        a_found;
    logic                new_match;
    logic                capture;

    always_comb begin
        out_busy = '0;
        in_busy  = '0;
        for (int unsigned j = 0; j < M; j++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (match_q[j][i]) begin
                    out_busy[j] = 1'b1;
                    in_busy[i]  = 1'b1;
                end
            end
        end
    end

    // Round-robin as two passes: indices at/above the pointer first, then the wrap-around.
    always_comb begin
        gnt_w   = '0;
        g_found = '0;
        for (int unsigned j = 0; j < M; j++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!out_busy[j] && !g_found[j] && i >= 32'(gptr_q[j]) &&
                    req_q[i][j] && !in_busy[i]) begin
                    gnt_w[j][i] = 1'b1;
                    g_found[j]  = 1'b1;
                end
            end
            for (int unsigned i = 0; i < N; i++) begin
                if (!out_busy[j] && !g_found[j] && req_q[i][j] && !in_busy[i]) begin
                    gnt_w[j][i] = 1'b1;
                    g_found[j]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        acc_w   = '0;
        a_found = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < M; j++) begin
                if (!a_found[i] && j >= 32'(aptr_q[i]) && gnt_w[j][i]) begin
                    acc_w[j][i] = 1'b1;
                    a_found[i]  = 1'b1;
                end
            end
            for (int unsigned j = 0; j < M; j++) begin
                if (!a_found[i] && gnt_w[j][i]) begin
                    acc_w[j][i] = 1'b1;
                    a_found[i]  = 1'b1;
                end
            end
        end
    end

    assign new_match = |acc_w;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        match_d = match_q;
        grant_d = grant_q;
        gptr_d  = gptr_q;
        aptr_d  = aptr_q;
        iter_d  = iter_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        capture = 1'b0;

        unique case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                capture = i_start;
            end
            ITERATE: begin
                match_d = match_q | acc_w;
                if (iter_q == KW'(1)) begin
                    for (int unsigned j = 0; j < M; j++) begin
                        for (int unsigned i = 0; i < N; i++) begin
                            if (acc_w[j][i]) begin
                                gptr_d[j] = (i == N - 1) ? '0 : NW'(i + 1);
                                aptr_d[i] = (j == M - 1) ? '0 : MW'(j + 1);
                            end
                        end
                    end
                end
                if (!new_match || iter_q == KW'(ITER)) begin
                    state_d = DONE;
                    grant_d = match_q | acc_w;
                end else begin
                    iter_d = iter_q + KW'(1);
                end
            end
            DONE: begin
                o_ready = 1'b1;
                o_valid = 1'b1;
                capture = i_start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            req_d   = i_request;
            match_d = '0;
            iter_d  = KW'(1);
            state_d = ITERATE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            match_q <= '0;
            grant_q <= '0;
            gptr_q  <= '0;
            aptr_q  <= '0;
            iter_q  <= KW'(1);
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            match_q <= match_d;
            grant_q <= grant_d;
            gptr_q  <= gptr_d;
            aptr_q  <= aptr_d;
            iter_q  <= iter_d;
        end
    end

    assign o_grant = grant_q;

endmodule

// File: tb/tb_lib_allocator_islip_iter.sv
// Bench for lib_allocator_islip_iter: two configurations (4x4/ITER=4 and
// 3x5/ITER=2) checked against a behavioural iSLIP model.
module tb_lib_allocator_islip_iter;

    typedef logic [7:0][7:0] mat_t;

    logic            clk     = 1'b0;
    logic            reset_n = 1'b0;
    logic            start_a = 1'b0;
    logic            start_b = 1'b0;
    logic [3:0][3:0] req_a   = '0;
    logic [2:0][4:0] req_b   = '0;
    logic            ready_a, valid_a, ready_b, valid_b;
    logic [3:0][3:0] grant_a;
    logic [4:0][2:0] grant_b;

    int checks = 0;
    int errors = 0;
    int gp[2][8];
    int ap[2][8];

    always #5 clk = ~clk;

    lib_allocator_islip_iter #(.N(4), .M(4), .ITER(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .i_start(start_a), .i_request(req_a),
        .o_ready(ready_a), .o_valid(valid_a), .o_grant(grant_a)
    );

    lib_allocator_islip_iter #(.N(3), .M(5), .ITER(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .i_start(start_b), .i_request(req_b),
        .o_ready(ready_b), .o_valid(valid_b), .o_grant(grant_b)
    );

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int m_of(input int d);
        return (d == 0) ? 4 : 5;
    endfunction

    function automatic int it_of(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic logic valid_of(input int d);
        return (d == 0) ? valid_a : valid_b;
    endfunction

    function automatic logic ready_of(input int d);
        return (d == 0) ? ready_a : ready_b;
    endfunction

    function automatic mat_t grant_of(input int d);
        mat_t g;
        g = '0;
        if (d == 0) begin
            for (int j = 0; j < 4; j++)
                for (int i = 0; i < 4; i++) g[j][i] = grant_a[j][i];
        end else begin
            for (int j = 0; j < 5; j++)
                for (int i = 0; i < 3; i++) g[j][i] = grant_b[j][i];
        end
        return g;
    endfunction

    function automatic mat_t rand_req(input int d);
        mat_t r;
        int   dens;
        r    = '0;
        dens = $urandom_range(1, 4);
        for (int i = 0; i < n_of(d); i++)
            for (int j = 0; j < m_of(d); j++)
                r[i][j] = ($urandom_range(0, 4) < dens);
        return r;
    endfunction

    task automatic drive(input int d, input logic s, input mat_t rq);
        if (d == 0) begin
            start_a = s;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) req_a[i][j] = rq[i][j];
        end else begin
            start_b = s;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 5; j++) req_b[i][j] = rq[i][j];
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++)
            for (int x = 0; x < 8; x++) begin
                gp[d][x] = 0;
                ap[d][x] = 0;
            end
    endtask

    // Reference: iteration-by-iteration matching from the iSLIP rules, with
    // pointers moved only by first-iteration matches.
    task automatic model_alloc(input int d, input mat_t rq, output mat_t mg, output int kr);
        int n, m, it, added, ii, jj;
        int gsel[8];
        bit om[8], im[8];
        bit hit, stop;
        n = n_of(d); m = m_of(d); it = it_of(d);
        mg = '0; kr = 0; stop = 0;
        for (int x = 0; x < 8; x++) begin om[x] = 0; im[x] = 0; gsel[x] = -1; end
        for (int k = 1; k <= it && !stop; k++) begin
            kr = k; added = 0;
            for (int j = 0; j < m; j++) begin
                gsel[j] = -1;
                if (!om[j])
                    for (int s = 0; s < n; s++) begin
                        ii = (gp[d][j] + s) % n;
                        if (gsel[j] < 0 && rq[ii][j] && !im[ii]) gsel[j] = ii;
                    end
            end
            for (int i = 0; i < n; i++) begin
                if (!im[i]) begin
                    hit = 0;
                    for (int s = 0; s < m; s++) begin
                        jj = (ap[d][i] + s) % m;
                        if (!hit && gsel[jj] == i) begin
                            hit = 1; mg[jj][i] = 1; om[jj] = 1; im[i] = 1; added++;
                            if (k == 1) begin
                                gp[d][jj] = (i + 1) % n;
                                ap[d][i]  = (jj + 1) % m;
                            end
                        end
                    end
                end
            end
            if (added == 0) stop = 1;
        end
    endtask

    // Starts an allocation at the current cycle and waits (bounded) for o_valid.
    task automatic run_alloc(input int d, input mat_t rq, input bit inject,
                             output mat_t obs, output int lat, output int ready_bad);
        drive(d, 1'b1, rq);
        @(posedge clk); #1;
        drive(d, 1'b0, rq);
        lat = 1; ready_bad = 0;
        while (!valid_of(d) && lat < 20) begin
            if (ready_of(d) !== 1'b0) ready_bad++;
            if (inject && lat == 2) drive(d, 1'b1, rand_req(d));
            @(posedge clk); #1;
            lat++;
            drive(d, 1'b0, rq);
        end
        obs = grant_of(d);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %b want 1", ready_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
        checks++; if (grant_a !== '0) begin errors++; $display("FAIL reset_grant_a: got %h want 0", grant_a); end
        checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %b want 1", ready_b); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", valid_b); end
        checks++; if (grant_b !== '0) begin errors++; $display("FAIL reset_grant_b: got %h want 0", grant_b); end
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_full_pair();
        mat_t full, obs, exp, mexp;
        int   lat, rb, k;
        full = '0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) full[i][j] = 1'b1;
        exp = '0;
        for (int x = 0; x < 4; x++) exp[x][x] = 1'b1;
        model_alloc(0, full, mexp, k);
        run_alloc(0, full, 0, obs, lat, rb);
        checks++; if (obs !== exp) begin errors++; $display("FAIL full_first_grant: got %h want %h", obs, exp); end
        checks++; if (lat != 5) begin errors++; $display("FAIL full_first_latency: got %0d want 5", lat); end
        checks++; if (rb != 0) begin errors++; $display("FAIL full_first_ready_low: got %0d ready cycles want 0", rb); end
        // back-to-back from the DONE cycle
        exp = '0;
        exp[1][0] = 1'b1; exp[0][1] = 1'b1; exp[2][2] = 1'b1; exp[3][3] = 1'b1;
        model_alloc(0, full, mexp, k);
        run_alloc(0, full, 0, obs, lat, rb);
        checks++; if (obs !== exp) begin errors++; $display("FAIL full_second_grant: got %h want %h", obs, exp); end
        checks++; if (lat != 5) begin errors++; $display("FAIL full_second_latency: got %0d want 5", lat); end
    endtask

    task automatic test_early_term();
        mat_t rq, obs, exp, mexp;
        int   lat, rb, k;
        @(posedge clk); #1;
        checks++; if (ready_a !== 1'b1 || valid_a !== 1'b0) begin
            errors++; $display("FAIL idle_after_done: got ready=%b valid=%b want 1/0", ready_a, valid_a);
        end
        rq = '0; rq[2][3] = 1'b1;
        exp = '0; exp[3][2] = 1'b1;
        model_alloc(0, rq, mexp, k);
        run_alloc(0, rq, 0, obs, lat, rb);
        checks++; if (obs !== exp) begin errors++; $display("FAIL early_term_grant: got %h want %h", obs, exp); end
        checks++; if (lat != 3) begin errors++; $display("FAIL early_term_latency: got %0d want 3", lat); end
    endtask

    task automatic test_all_zero();
        mat_t obs, mexp;
        int   lat, rb, k;
        model_alloc(0, '0, mexp, k);
        run_alloc(0, '0, 0, obs, lat, rb);
        checks++; if (obs !== '0) begin errors++; $display("FAIL all_zero_grant: got %h want 0", obs); end
        checks++; if (lat != 2) begin errors++; $display("FAIL all_zero_latency: got %0d want 2", lat); end
    endtask

    task automatic test_rotate_b();
        mat_t rq, obs, exp, mexp;
        int   lat, rb, k;
        rq = '0;
        for (int j = 0; j < 5; j++) rq[2][j] = 1'b1;
        for (int a = 0; a < 6; a++) begin
            exp = '0; exp[a % 5][2] = 1'b1;
            model_alloc(1, rq, mexp, k);
            run_alloc(1, rq, 0, obs, lat, rb);
            checks++; if (obs !== exp) begin errors++; $display("FAIL rotate_b_grant[%0d]: got %h want %h", a, obs, exp); end
            checks++; if (lat != 3) begin errors++; $display("FAIL rotate_b_latency[%0d]: got %0d want 3", a, lat); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        mat_t rq, obs, mexp;
        int   lat, rb, k, extra;
        rq = '0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) rq[i][j] = 1'b1;
        rq[0][0] = 1'b0;
        model_alloc(0, rq, mexp, k);
        run_alloc(0, rq, 1, obs, lat, rb);
        checks++; if (obs !== mexp) begin errors++; $display("FAIL ignore_start_grant: got %h want %h", obs, mexp); end
        checks++; if (lat != k + 1) begin errors++; $display("FAIL ignore_start_latency: got %0d want %0d", lat, k + 1); end
        extra = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (valid_a !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ignore_start_extra_valid: got %0d strobes want 0", extra); end
    endtask

    task automatic test_back_to_back();
        mat_t rq, obs, mexp;
        int   lat, rb, k;
        for (int n = 0; n < 6; n++) begin
            rq = rand_req(0);
            model_alloc(0, rq, mexp, k);
            run_alloc(0, rq, 0, obs, lat, rb);
            checks++; if (obs !== mexp) begin errors++; $display("FAIL b2b_grant[%0d]: got %h want %h", n, obs, mexp); end
            checks++; if (lat != k + 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", n, lat, k + 1); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midrun();
        mat_t full, obs, exp;
        int   lat, rb, bad;
        full = '0;
        for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) full[i][j] = 1'b1;
        drive(0, 1'b1, full);
        @(posedge clk); #1;
        drive(0, 1'b0, full);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        bad = 0;
        repeat (6) begin
            if (valid_a !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL midrun_reset_valid: got %0d strobes want 0", bad); end
        checks++; if (grant_a !== '0 || ready_a !== 1'b1) begin
            errors++; $display("FAIL midrun_reset_state: got grant=%h ready=%b want 0/1", grant_a, ready_a);
        end
        exp = '0;
        for (int x = 0; x < 4; x++) exp[x][x] = 1'b1;
        run_alloc(0, full, 0, obs, lat, rb);
        checks++; if (obs !== exp) begin errors++; $display("FAIL midrun_reset_pointers: got %h want %h", obs, exp); end
        checks++; if (lat != 5) begin errors++; $display("FAIL midrun_reset_latency: got %0d want 5", lat); end
        begin
            mat_t mexp;
            int   k;
            model_alloc(0, full, mexp, k);
        end
    endtask

    task automatic test_random();
        mat_t rq, obs, mexp;
        int   lat, rb, k, d;
        for (int n = 0; n < 80; n++) begin
            d  = $urandom_range(0, 1);
            rq = rand_req(d);
            model_alloc(d, rq, mexp, k);
            run_alloc(d, rq, 0, obs, lat, rb);
            checks++; if (obs !== mexp) begin errors++; $display("FAIL random_grant[%0d] dut%0d: got %h want %h", n, d, obs, mexp); end
            checks++; if (lat != k + 1) begin errors++; $display("FAIL random_latency[%0d] dut%0d: got %0d want %0d", n, d, lat, k + 1); end
            checks++; if (rb != 0) begin errors++; $display("FAIL random_ready_low[%0d] dut%0d: got %0d want 0", n, d, rb); end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_pair();
        test_early_term();
        test_all_zero();
        @(posedge clk); #1;
        test_rotate_b();
        test_ignore_start();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
